rca_seq_add_ctrl: RTL and testbench



---
 rtl/rca_seq_add_ctrl_pkg.sv | 23 ++
 rtl/rca_seq_add_ctrl_if.sv | 28 ++
 rtl/rca_seq_add_ctrl_rca4_cin.sv | 39 +++
 rtl/rca_seq_add_ctrl.sv | 105 ++++++++++
 tb/tb_rca_seq_add_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rca_seq_add_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential ripple-carry add/sub controller.
package rca_seq_pkg;

    // Width of the single ripple-carry slice that is reused every cycle.
    localparam int CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit so the counter always exists.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rca_seq_add_ctrl_if.sv
// Request/result handshake bundle between producer, controller and consumer.
interface rca_seq_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic             busy;

    // Controller side.
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, busy
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, busy
    );
endinterface

// File: rtl/rca_seq_add_ctrl_rca4_cin.sv
// 4-bit ripple-carry slice with explicit carry-in, chained from single-bit full adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca4_cin
    import rca_seq_pkg::*;
(
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            full_adder u_fa (
                .a   (a[gi]),
                .b   (b[gi]),
                .cin (c[gi]),
                .sum (sum[gi]),
                .cout(c[gi+1])
            );
        end
    endgenerate

    assign cout = c[CHUNK];
endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Time-multiplexed WIDTH-bit add/subtract: one 4-bit slice walks the operands LSB chunk first,
// with the inter-chunk carry held in a register between cycles.
module rca_seq_add_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    rca_seq_add_ctrl_if.slave   bus
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = clog2(NCH);
    localparam int MSB   = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 8) begin : g_bad_width
            $error("rca_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cy_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             valid_reg;
    logic             busy_reg;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    rca4_cin u_slice (
        .a   (a_reg[idx_reg*CHUNK +: CHUNK]),
        .b   (b_reg[idx_reg*CHUNK +: CHUNK]),
        .cin (cy_reg),
        .sum (slice_sum),
        .cout(slice_cout)
    );

    // Sequencer: latch operands on accept, run one chunk per cycle, hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cy_reg    <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
                        a_reg     <= bus.in_a;
                        b_reg     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        cy_reg    <= bus.in_sub;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg*CHUNK +: CHUNK] <= slice_sum;
                    cy_reg  <= slice_cout;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        // The top chunk's slice output gives both flags directly.
                        carry_reg <= slice_cout;
                        ovf_reg   <= (a_reg[MSB] == b_reg[MSB]) &&
                                     (slice_sum[CHUNK-1] != a_reg[MSB]);
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = valid_reg;
    assign bus.out_sum   = sum_reg;
    assign bus.out_carry = carry_reg;
    assign bus.out_ovf   = ovf_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Self-checking bench for rca_seq_add_ctrl (WIDTH=16): directed corner cases plus a random stream
// compared every cycle against an arithmetic reference model.
module tb_rca_seq_add_ctrl;
    localparam int W = 16;

    logic clk;
    logic rst;

    rca_seq_add_ctrl_if #(.WIDTH(W)) bus_if ();

    rca_seq_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference result {ovf, carry, sum} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        int sa, sb, r;
        logic c, o;
        logic [W-1:0] s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        o  = (r > 32767) || (r < -32768);
        c  = sub ? (a >= b) : ((32'(a) + 32'(b)) > 32'h0000_FFFF);
        s  = sub ? a - b : a + b;
        return {o, c, s};
    endfunction

    // Behavioural model: accept when idle, result visible W/4 edges later, leave on out_ready.
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cnt   = 0;
    int          m_done  = 0;
    logic [17:0] m_pend  = '0;
    logic [17:0] m_out   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            if (bus_if.in_valid) begin
                m_pend <= ref_op(bus_if.in_a, bus_if.in_b, bus_if.in_sub);
                m_busy <= 1'b1;
                m_cnt  <= W / 4;
            end
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_out   <= m_pend;
            end
            m_cnt <= m_cnt - 1;
        end else if (m_valid && bus_if.out_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_done  <= m_done + 1;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("in_ready", 32'(bus_if.in_ready), 32'(!m_busy));
        chk("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
        chk("busy", 32'(bus_if.busy), 32'(m_busy));
        if (m_valid) begin
            chk("out_sum", 32'(bus_if.out_sum), 32'(m_out[15:0]));
            chk("out_carry", 32'(bus_if.out_carry), 32'(m_out[16]));
            chk("out_ovf", 32'(bus_if.out_ovf), 32'(m_out[17]));
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] es, input logic ec, input logic eo, input int hold);
        int lat;
        lat = 0;
        while (!bus_if.in_ready && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("ready_before_op", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_a      = a;
        bus_if.in_b      = b;
        bus_if.in_sub    = sub;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble operands after acceptance; they must not matter.
        bus_if.in_valid = 1'b0;
        bus_if.in_a     = W'($urandom);
        bus_if.in_b     = W'($urandom);
        bus_if.in_sub   = ~sub;
        chk("busy_after_accept", 32'(bus_if.busy), 32'd1);
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("lit_sum", 32'(bus_if.out_sum), 32'(es));
        chk("lit_carry", 32'(bus_if.out_carry), 32'(ec));
        chk("lit_ovf", 32'(bus_if.out_ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            bus_if.in_valid = ~bus_if.in_valid;
            bus_if.in_a     = W'($urandom);
            @(posedge clk); #1;
            chk("hold_sum", 32'(bus_if.out_sum), 32'(es));
            chk("hold_carry", 32'(bus_if.out_carry), 32'(ec));
            chk("hold_ovf", 32'(bus_if.out_ovf), 32'(eo));
            chk("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
            chk("hold_valid", 32'(bus_if.out_valid), 32'd1);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        chk("release_valid", 32'(bus_if.out_valid), 32'd0);
        chk("release_ready", 32'(bus_if.in_ready), 32'd1);
        chk("release_sum_kept", 32'(bus_if.out_sum), 32'(es));
        $display("op a=%h b=%h sub=%0d -> sum=%h carry=%0d ovf=%0d latency=%0d",
                 a, b, sub, es, ec, eo, lat);
    endtask

    initial begin
        int start, cyc;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.in_sub    = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_sum", 32'(bus_if.out_sum), 32'd0);
        chk("rst_carry", 32'(bus_if.out_carry), 32'd0);
        chk("rst_ovf", 32'(bus_if.out_ovf), 32'd0);
        rst = 1'b0;

        // Pin the reference model against hand-computed values.
        chk("ref_00ff_p_1", 32'(ref_op(16'h00FF, 16'h0001, 1'b0)), 32'h00100);
        chk("ref_ffff_p_1", 32'(ref_op(16'hFFFF, 16'h0001, 1'b0)), 32'h10000);
        chk("ref_7fff_p_1", 32'(ref_op(16'h7FFF, 16'h0001, 1'b0)), 32'h28000);
        chk("ref_5_m_7", 32'(ref_op(16'h0005, 16'h0007, 1'b1)), 32'h0FFFE);
        chk("ref_8000_m_1", 32'(ref_op(16'h8000, 16'h0001, 1'b1)), 32'h37FFF);

        @(posedge clk); #1;
        do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 5);

        // Reset in the middle of RUN.
        bus_if.in_a     = 16'hABCD;
        bus_if.in_b     = 16'h1357;
        bus_if.in_sub   = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus_if.busy), 32'd0);
        chk("midrst_sum", 32'(bus_if.out_sum), 32'd0);
        chk("midrst_carry", 32'(bus_if.out_carry), 32'd0);
        chk("midrst_ovf", 32'(bus_if.out_ovf), 32'd0);
        $display("reset asserted mid-run");
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

        // Random stream with random valid/ready, checked by the compare process.
        start = m_done;
        cyc   = 0;
        while ((m_done - start) < 1000 && cyc < 40000) begin
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.in_a      = W'($urandom);
            bus_if.in_b      = W'($urandom);
            bus_if.in_sub    = 1'($urandom_range(0, 1));
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_ops_completed", 32'(m_done - start), 32'd1000);
        $display("random stream: %0d ops in %0d cycles", m_done - start, cyc);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
